// File: rtl/dot_pkg.sv
// Shared types and constants for the 8x8 dot-matrix scan controller.
package dot_pkg;

  localparam int NCOL = 8;
  localparam int NROW = 8;

  typedef logic [2:0]      col_t;
  typedef logic [NROW-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Phase counter width; never below one bit so a 1-cycle interval still has a register.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dot_fbuf.sv
// Two-bank 8x8 frame store: writes always go to the back bank, reads come from the front bank.
module dot_fbuf
  import dot_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic wr_en_i,
  input  col_t wr_addr_i,
  input  row_t wr_data_i,
  input  logic front_i,
  input  col_t rd_addr_i,
  output row_t rd_data_o
);

  row_t bank_q [2][NCOL];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCOL; c++) begin
          bank_q[b][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      bank_q[~front_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = bank_q[front_i][rd_addr_i];

endmodule

// File: rtl/dot_scan_ctrl.sv
// Column scan controller for the 8x8 dot matrix: blank/show sequencing per column,
// tear-free buffer swap at the frame boundary, all outputs registered.
module dot_scan_ctrl
  import dot_pkg::*;
#(
  parameter int BLANK_CYC = 16,
  parameter int SHOW_CYC  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       swap,
  output logic [2:0] col_sel,
  output logic [7:0] row,
  output logic       frame_done,
  output logic       swap_pend
);

  localparam int CNT_W = cnt_width(BLANK_CYC, SHOW_CYC);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam col_t             COL_ONE    = col_t'(1);
  localparam col_t             COL_LAST   = col_t'(NCOL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  col_t             col_q, col_d;
  row_t             row_q, row_d;
  logic             fd_q, fd_d;
  logic             pend_q, pend_d;
  logic             front_q, front_d;
  logic             wrap;
  row_t             rd_data;

  dot_fbuf u_fbuf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .front_i   (front_q),
    .rd_addr_i (col_q),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fd_q    <= 1'b0;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fd_q    <= fd_d;
      pend_q  <= pend_d;
      front_q <= front_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    col_d   = col_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          col_d   = '0;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            col_d   = col_q + COL_ONE;
            wrap    = (col_q == COL_LAST);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // Front only changes at a frame wrap or in IDLE, so the row read stays stable through SHOW.
  always_comb begin
    row_d   = (state_d == SHOW) ? rd_data : '0;
    fd_d    = wrap;
    front_d = front_q;
    pend_d  = pend_q | swap;
    if (wrap) begin
      front_d = front_q ^ (pend_q | swap);
      pend_d  = 1'b0;
    end else if (state_q == IDLE && pend_q) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
    end
  end

  assign col_sel    = col_q;
  assign row        = row_q;
  assign frame_done = fd_q;
  assign swap_pend  = pend_q;

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// Scoreboard bench for dot_scan_ctrl with BLANK_CYC=2, SHOW_CYC=4.
module tb_dot_scan_ctrl;

  localparam int B     = 2;
  localparam int S     = 4;
  localparam int COLP  = B + S;
  localparam int FRAME = 8 * COLP;

  typedef struct packed {
    logic [2:0] col;
    logic [7:0] row;
    logic       fd;
    logic       pend;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       swap = 1'b0;
  logic [2:0] col_sel;
  logic [7:0] row;
  logic       frame_done;
  logic       swap_pend;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time since the column-0 BLANK entry drives everything.
  int         m_run = 0;
  int         m_t = 0;
  int         m_front = 0;
  bit         m_pend = 1'b0;
  logic [7:0] bank [2][8];

  obs_t sb_q [$];

  int         fd_seen, pend_seen, hit_seen, nz_seen;
  logic [7:0] watch_pat = 8'h00;

  dot_scan_ctrl #(.BLANK_CYC(B), .SHOW_CYC(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap       (swap),
    .col_sel    (col_sel),
    .row        (row),
    .frame_done (frame_done),
    .swap_pend  (swap_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_run = 0; m_t = 0; m_front = 0; m_pend = 1'b0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++) bank[b][c] = 8'h00;
    end else begin
      if (wr_en) bank[1 - m_front][int'(wr_addr)] = wr_data;
      if (m_run == 0) begin
        if (m_pend) begin
          m_front = 1 - m_front;
          m_pend  = 1'b0;
        end else begin
          m_pend = swap;
        end
        m_run = en ? 1 : 0;
        m_t   = 0;
      end else if (!en) begin
        m_pend = m_pend | swap;
        m_run  = 0;
        m_t    = 0;
      end else begin
        if (m_t % FRAME == FRAME - 1) begin
          if (m_pend || swap) m_front = 1 - m_front;
          m_pend = 1'b0;
        end else begin
          m_pend = m_pend | swap;
        end
        m_t++;
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   c, ph;
    o      = '0;
    o.pend = m_pend;
    if (m_run != 0) begin
      c     = (m_t / COLP) % 8;
      ph    = m_t % COLP;
      o.col = 3'(c);
      o.row = (ph >= B) ? bank[m_front][c] : 8'h00;
      o.fd  = (m_t > 0) && (m_t % FRAME == 0);
    end
    return o;
  endfunction

  task automatic clr();
    fd_seen = 0; pend_seen = 0; hit_seen = 0; nz_seen = 0;
  endtask

  task automatic tick();
    obs_t e;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("col_sel", 32'(col_sel), 32'(e.col));
    chk("row", 32'(row), 32'(e.row));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
    chk("swap_pend", 32'(swap_pend), 32'(e.pend));
    fd_seen   += int'(frame_done);
    pend_seen += int'(swap_pend);
    if (row == watch_pat) hit_seen++;
    if (row != 8'h00) nz_seen++;
    reset = 1'b0;
    wr_en = 1'b0;
    swap  = 1'b0;
  endtask

  task automatic run_to_wrap();
    for (int i = 0; i < FRAME && (m_run == 0 || (m_t % FRAME) != FRAME - 1); i++) tick();
  endtask

  initial begin
    // Reset, then free-running scan with empty buffers.
    reset = 1'b1; tick();
    chk("rst_col", 32'(col_sel), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_pend", 32'(swap_pend), 32'd0);
    tick(); tick();
    clr();
    en = 1'b1;
    for (int i = 0; i <= 2 * FRAME; i++) tick();
    chk("clear_fd_pulses", 32'(fd_seen), 32'd2);
    chk("clear_rows_dark", 32'(nz_seen), 32'd0);

    // Load back[3]=A5, swap together with enable.
    en = 1'b0; tick();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; tick();
    clr();
    swap = 1'b1; en = 1'b1; tick();
    for (int i = 0; i < FRAME; i++) tick();
    chk("pend_until_wrap", 32'(pend_seen), 32'(FRAME));
    clr(); watch_pat = 8'hA5;
    for (int i = 0; i < FRAME; i++) tick();
    chk("a5_show_cycles", 32'(hit_seen), 32'(S));

    // Swap on the exact wrap edge.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h3C; tick();
    clr();
    run_to_wrap();
    swap = 1'b1; tick();
    tick();
    chk("wrap_swap_no_pend", 32'(pend_seen), 32'd0);
    clr(); watch_pat = 8'h3C;
    for (int i = 0; i < FRAME; i++) tick();
    chk("wrap_swap_bank", 32'(hit_seen), 32'(S));

    // Abort mid-SHOW of column 5, then restart.
    for (int i = 0; i < FRAME && (m_t % FRAME) != 5 * COLP + B + 1; i++) tick();
    en = 1'b0; tick();
    chk("abort_col", 32'(col_sel), 32'd0);
    chk("abort_row", 32'(row), 32'd0);
    en = 1'b1; tick();
    chk("restart_col", 32'(col_sel), 32'd0);
    for (int i = 0; i < COLP + 2; i++) tick();

    // Back-buffer write is invisible until the next applied swap.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; tick();
    clr(); watch_pat = 8'hFF;
    for (int i = 0; i < FRAME; i++) tick();
    chk("back_write_hidden", 32'(hit_seen), 32'd0);
    swap = 1'b1; tick();
    run_to_wrap();
    tick();
    clr();
    for (int i = 0; i < FRAME; i++) tick();
    chk("back_write_shown", 32'(hit_seen), 32'(S));

    // Mid-frame reset with data loaded clears both banks.
    for (int i = 0; i < 2 * COLP + 3; i++) tick();
    reset = 1'b1; tick();
    chk("midrst_col", 32'(col_sel), 32'd0);
    chk("midrst_row", 32'(row), 32'd0);
    chk("midrst_pend", 32'(swap_pend), 32'd0);
    clr();
    swap = 1'b1; tick();
    for (int i = 0; i < 2 * FRAME + 2; i++) tick();
    chk("midrst_banks_zero", 32'(nz_seen), 32'd0);
    chk("midrst_fd_pulses", 32'(fd_seen), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dot_scan_ctrl.md
# dot_scan_ctrl

Scan controller for the 8x8 dot-matrix display. It cycles through the eight columns: it drives the 3-bit column index consumed by the column decoder (`dot_dec_x`) and the matching 8-bit row pattern from an internal double-buffered frame store. A blanking interval between columns suppresses ghosting. The CPU side writes the back buffer and requests a swap, which is applied only at a frame boundary, so a displayed frame never tears.

## Interface
- `BLANK_CYC`, default 16: cycles per column with rows forced off; minimum 1.
- `SHOW_CYC`, default 1000: cycles per column with row pattern shown; minimum 1.

- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high.
- `en` in 1: scan enable; low forces the idle state.
- `wr_en` in 1: write strobe to the back buffer.
- `wr_addr` in 3: column index of the write.
- `wr_data` in 8: row pattern for that column; bit i is row i, 1 = lit.
- `swap` in 1: single-cycle request to exchange the front and back buffers.
- `col_sel` out 3: column index to `dot_dec_x`.
- `row` out 8: active-high row drive.
- `frame_done` out 1: one-cycle pulse at the end of the column-7 show interval.
- `swap_pend` out 1: high from the swap request until the swap is applied.

## Operation
- States:
  - IDLE: `row`=0, `col_sel`=0.
  - BLANK: `row`=0.
  - SHOW: `row`=front[`col_sel`].
- Transitions:
  - IDLE→BLANK when `en`=1.
  - BLANK→SHOW after BLANK_CYC cycles.
  - SHOW→BLANK after SHOW_CYC cycles. On this transition `col_sel` increments and wraps 7→0.
  - Any state→IDLE when `en`=0. The abort takes effect at the next edge and clears `col_sel` and the phase counter.
- Phase counter:
  - Width is $clog2(max(BLANK_CYC,SHOW_CYC)).
  - Loaded to 0 on every state entry; terminal value is CYC-1.
- Frame store:
  - Two banks of 8x8 bits, selected by the `front` bit.
  - A write with `wr_en`=1 stores `wr_data` into back[`wr_addr`] at the edge. The front bank is never written.
- Swap:
  - `swap`=1 sets `swap_pend`.
  - At the SHOW→BLANK transition from column 7, a pending swap toggles `front` and clears `swap_pend` in the same edge. `frame_done` pulses on that edge.
  - A swap arriving on the same edge as the wrap is applied immediately; `swap_pend` stays 0.
  - Repeated swaps while pending merge into one.
  - While in IDLE, a pending swap is applied at the next edge.
- A write to the back buffer on the same cycle as a swap lands in the bank that was back before the swap, i.e. the new front.
- Reset values:
  - `row`=0, `col_sel`=0, `frame_done`=0, `swap_pend`=0.
  - `front`=0, state IDLE.
  - Both banks cleared to 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `en` rises at edge N → BLANK from N+1 with `col_sel`=0. The first nonzero `row` appears at N+1+BLANK_CYC.
- Column period is BLANK_CYC+SHOW_CYC cycles; frame period is 8×(BLANK_CYC+SHOW_CYC).
- `col_sel` changes only at entry to BLANK, so the column switches while rows are dark.
- `row` during SHOW reflects the front bank and stays constant for the whole interval.
- Reset asserted mid-frame wins over all other inputs at that edge.

## Structure
- Package `dot_pkg` holds:
  - the state enum (IDLE, BLANK, SHOW);
  - the `NCOL`=8 and `NROW`=8 constants;
  - the column index typedef (3 bits) and the row pattern typedef (8 bits).
- Sub-module `dot_fbuf` is the two-bank 8x8 register file. It has one write port (back bank) and one read port (front bank, addressed by `col_sel`), plus the `front` select.
- The FSM, phase counter and swap logic live in `dot_scan_ctrl`.

## Test plan
All scenarios use BLANK_CYC=2 and SHOW_CYC=4.
- Reset then `en`=1: column period 6; `col_sel` steps 0..7 and wraps; `row`=0 throughout because the buffers are clear; `frame_done` pulses every 48 cycles.
- Write back[3]=8'hA5, pulse `swap`, `en`=1: `swap_pend` stays 1 until the first frame end. The next frame shows `row`=8'hA5 only during the column-3 SHOW interval, and 0 elsewhere.
- `swap` asserted on the exact column-7 wrap edge: `swap_pend` never goes high, and the new frame uses the swapped bank.
- Drop `en` mid-SHOW of column 5: next edge `row`=0, `col_sel`=0, state IDLE. Re-enabling restarts at BLANK of column 0.
- `reset` pulse mid-frame with data loaded: all outputs return to reset values and both banks read back 0.
- Write a different pattern to back[0] while the front is displayed: `row` for column 0 is unchanged until the next applied swap.
